// File: rtl/register_file_wb_pkg.sv
// Shared constants and types for the writeback register file.
//   REGFILE_DATA_W  : register / writeback data width
//   WB_COUNT_W      : committed-write counter width
//   DEFAULT_NREGS   : default number of registers
//   DEFAULT_ADDR_W  : default register index width (log2 of DEFAULT_NREGS)
//   reg_idx_t       : register index type at the default configuration
package register_file_wb_pkg;
  localparam int unsigned REGFILE_DATA_W = 32;
  localparam int unsigned WB_COUNT_W     = 16;
  localparam int unsigned DEFAULT_NREGS  = 16;
  localparam int unsigned DEFAULT_ADDR_W = 4;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/register_file_wb_read_port.sv
// regfile_read_port: one registered read port of the register file.
// Optional macro WB_BYPASS_EN enables write-through bypass of a committing
// writeback onto this port; otherwise the old register value is returned.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   stall      : 1 holds rd_data
//   rd_idx     : register index to read
//   regs       : packed register array contents
//   wr_commit  : a writeback commits at this edge (never to index 0)
//   wr_idx     : committing writeback index
//   wr_data    : committing writeback data
//   rd_data    : registered read data (one-cycle latency)
module regfile_read_port
  import register_file_wb_pkg::*;
#(
  parameter int unsigned NREGS  = DEFAULT_NREGS,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stall,
  input  logic [ADDR_W-1:0]                    rd_idx,
  input  logic [NREGS-1:0][REGFILE_DATA_W-1:0] regs,
  input  logic                                 wr_commit,
  input  logic [ADDR_W-1:0]                    wr_idx,
  input  logic [REGFILE_DATA_W-1:0]            wr_data,
  output logic [REGFILE_DATA_W-1:0]            rd_data
);
  logic [REGFILE_DATA_W-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    if (rd_idx != '0) begin
      rd_next = regs[rd_idx];
`ifdef WB_BYPASS_EN
      // wr_commit is never asserted for index 0, so index 0 is never bypassed.
      if (wr_commit && (wr_idx == rd_idx)) rd_next = wr_data;
`endif
    end
  end

`ifndef WB_BYPASS_EN
  logic unused_wr;
  assign unused_wr = wr_commit ^ (^wr_idx) ^ (^wr_data);
`endif

  always_ff @(posedge clk) begin
    if (rst)         rd_data <= '0;
    else if (!stall) rd_data <= rd_next;
  end
endmodule

// File: rtl/register_file_wb.sv
// register_file_wb: NREGS x 32-bit register file with a writeback write port,
// two registered read ports, a saturating committed-write counter and a
// sticky out-of-range destination error flag. Register 0 reads as zero.
// Optional macro WB_BYPASS_EN: same-edge write-to-read bypass on both ports.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   EN           : stall, 1 freezes all state
//   i_WE_MEM_WB  : writeback enable
//   i_WB_Data    : writeback data
//   i_WB_Dir     : writeback destination index (32-bit, upper bits must be 0)
//   i_RA_Dir     : read port A index
//   i_RB_Dir     : read port B index
//   o_RA_Data    : registered read data, port A
//   o_RB_Data    : registered read data, port B
//   o_WB_Count   : committed-write counter, saturating
//   o_Dir_Err    : sticky out-of-range destination flag
module register_file_wb
  import register_file_wb_pkg::*;
#(
  parameter int unsigned NREGS  = DEFAULT_NREGS,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      EN,
  input  logic                      i_WE_MEM_WB,
  input  logic [REGFILE_DATA_W-1:0] i_WB_Data,
  input  logic [31:0]               i_WB_Dir,
  input  logic [ADDR_W-1:0]         i_RA_Dir,
  input  logic [ADDR_W-1:0]         i_RB_Dir,
  output logic [REGFILE_DATA_W-1:0] o_RA_Data,
  output logic [REGFILE_DATA_W-1:0] o_RB_Data,
  output logic [WB_COUNT_W-1:0]     o_WB_Count,
  output logic                      o_Dir_Err
);
  logic [NREGS-1:0][REGFILE_DATA_W-1:0] regs;
  logic [ADDR_W-1:0]                    wr_idx;
  logic                                 dir_oor;
  logic                                 wr_commit;

  assign wr_idx    = i_WB_Dir[ADDR_W-1:0];
  assign dir_oor   = (i_WB_Dir[31:ADDR_W] != '0);
  assign wr_commit = !rst && !EN && i_WE_MEM_WB && !dir_oor && (wr_idx != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs       <= '0;
      o_WB_Count <= '0;
      o_Dir_Err  <= 1'b0;
    end else if (!EN) begin
      if (wr_commit) begin
        regs[wr_idx] <= i_WB_Data;
        if (o_WB_Count != '1) o_WB_Count <= o_WB_Count + 1'b1;
      end
      if (i_WE_MEM_WB && dir_oor) o_Dir_Err <= 1'b1;
    end
  end

  regfile_read_port #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .stall     (EN),
    .rd_idx    (i_RA_Dir),
    .regs      (regs),
    .wr_commit (wr_commit),
    .wr_idx    (wr_idx),
    .wr_data   (i_WB_Data),
    .rd_data   (o_RA_Data)
  );

  regfile_read_port #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .stall     (EN),
    .rd_idx    (i_RB_Dir),
    .regs      (regs),
    .wr_commit (wr_commit),
    .wr_idx    (wr_idx),
    .wr_data   (i_WB_Data),
    .rd_data   (o_RB_Data)
  );
endmodule

// File: tb/tb_register_file_wb.sv
// Directed self-checking bench for register_file_wb (default NREGS=16).
module tb_register_file_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EN = 1'b0;
  logic        i_WE_MEM_WB = 1'b0;
  logic [31:0] i_WB_Data = '0;
  logic [31:0] i_WB_Dir = '0;
  logic [3:0]  i_RA_Dir = '0;
  logic [3:0]  i_RB_Dir = '0;
  logic [31:0] o_RA_Data;
  logic [31:0] o_RB_Data;
  logic [15:0] o_WB_Count;
  logic        o_Dir_Err;

  int unsigned checks = 0;
  int unsigned failures = 0;

  register_file_wb #(.NREGS(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .EN          (EN),
    .i_WE_MEM_WB (i_WE_MEM_WB),
    .i_WB_Data   (i_WB_Data),
    .i_WB_Dir    (i_WB_Dir),
    .i_RA_Dir    (i_RA_Dir),
    .i_RB_Dir    (i_RB_Dir),
    .o_RA_Data   (o_RA_Data),
    .o_RB_Data   (o_RB_Data),
    .o_WB_Count  (o_WB_Count),
    .o_Dir_Err   (o_Dir_Err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] dir, input logic [31:0] data);
    i_WE_MEM_WB = 1'b1;
    i_WB_Dir    = dir;
    i_WB_Data   = data;
  endtask

  logic [31:0] bypass_exp;

  initial begin
`ifdef WB_BYPASS_EN
    bypass_exp = 32'hA5A5A5A5;
`else
    bypass_exp = 32'h0;
`endif
    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ra", o_RA_Data, 32'h0);
    check("rst_rb", o_RB_Data, 32'h0);
    check("rst_cnt", {16'h0, o_WB_Count}, 32'h0);
    check("rst_err", {31'h0, o_Dir_Err}, 32'h0);

    // Basic write then read
    wr(32'd3, 32'hDEADBEEF);
    i_RA_Dir = 4'd0;
    tick();
    i_WE_MEM_WB = 1'b0;
    i_RA_Dir = 4'd3;
    tick();
    check("wr3_ra", o_RA_Data, 32'hDEADBEEF);
    check("wr3_cnt", {16'h0, o_WB_Count}, 32'd1);

    // Write to index 0 discarded
    wr(32'd0, 32'h12345678);
    i_RA_Dir = 4'd0;
    tick();
    i_WE_MEM_WB = 1'b0;
    tick();
    check("r0_ra", o_RA_Data, 32'h0);
    check("r0_cnt", {16'h0, o_WB_Count}, 32'd1);
    check("r0_err", {31'h0, o_Dir_Err}, 32'h0);

    // Same-edge write/read collision
    wr(32'd5, 32'hA5A5A5A5);
    i_RA_Dir = 4'd5;
    i_RB_Dir = 4'd5;
    tick();
    i_WE_MEM_WB = 1'b0;
    check("coll_ra", o_RA_Data, bypass_exp);
    check("coll_rb", o_RB_Data, bypass_exp);
    check("coll_cnt", {16'h0, o_WB_Count}, 32'd2);
    tick();
    check("coll_ra_next", o_RA_Data, 32'hA5A5A5A5);
    check("coll_rb_next", o_RB_Data, 32'hA5A5A5A5);

    // Both ports on same index
    i_RA_Dir = 4'd3;
    i_RB_Dir = 4'd3;
    tick();
    check("same_ra", o_RA_Data, 32'hDEADBEEF);
    check("same_rb", o_RB_Data, 32'hDEADBEEF);

    // Stall
    i_RB_Dir = 4'd5;
    tick();
    EN = 1'b1;
    wr(32'd3, 32'h11111111);
    i_RA_Dir = 4'd5;
    i_RB_Dir = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ra", o_RA_Data, 32'hDEADBEEF);
      check("stall_rb", o_RB_Data, 32'hA5A5A5A5);
      check("stall_cnt", {16'h0, o_WB_Count}, 32'd2);
    end
    i_WE_MEM_WB = 1'b0;
    EN = 1'b0;
    tick();
    check("resume_ra", o_RA_Data, 32'hA5A5A5A5);
    check("resume_rb", o_RB_Data, 32'hDEADBEEF);

    // Out-of-range destination
    wr(32'h00000010, 32'hFFFFFFFF);
    tick();
    check("oor_err", {31'h0, o_Dir_Err}, 32'h1);
    check("oor_cnt", {16'h0, o_WB_Count}, 32'd2);
    wr(32'h00000013, 32'h00000BAD);
    tick();
    wr(32'd7, 32'h00000077);
    tick();
    check("oor_err_sticky", {31'h0, o_Dir_Err}, 32'h1);
    check("oor_cnt_valid", {16'h0, o_WB_Count}, 32'd3);
    i_WE_MEM_WB = 1'b0;
    i_RA_Dir = 4'd7;
    i_RB_Dir = 4'd3;
    tick();
    check("oor_r7", o_RA_Data, 32'h00000077);
    check("oor_r3_kept", o_RB_Data, 32'hDEADBEEF);
    i_RA_Dir = 4'd0;
    tick();
    check("oor_r0", o_RA_Data, 32'h0);

    // Reset clears flag and contents
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_err", {31'h0, o_Dir_Err}, 32'h0);
    check("rst2_cnt", {16'h0, o_WB_Count}, 32'h0);
    i_RA_Dir = 4'd3;
    i_RB_Dir = 4'd7;
    tick();
    check("rst2_r3", o_RA_Data, 32'h0);
    check("rst2_r7", o_RB_Data, 32'h0);

    // Counter saturation
    wr(32'd1, 32'h0);
    for (int i = 0; i < 32'hFFFD; i++) begin
      i_WB_Data = i;
      tick();
    end
    check("cnt_fffd", {16'h0, o_WB_Count}, 32'h0000FFFD);
    tick();
    check("cnt_fffe", {16'h0, o_WB_Count}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cnt_sat", {16'h0, o_WB_Count}, 32'h0000FFFF);
    end

    // Reset during a write
    wr(32'd2, 32'h0000CAFE);
    i_RA_Dir = 4'd1;
    i_RB_Dir = 4'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_WE_MEM_WB = 1'b0;
    check("rstw_cnt", {16'h0, o_WB_Count}, 32'h0);
    check("rstw_ra", o_RA_Data, 32'h0);
    check("rstw_rb", o_RB_Data, 32'h0);
    check("rstw_err", {31'h0, o_Dir_Err}, 32'h0);
    tick();
    check("rstw_r1", o_RA_Data, 32'h0);
    check("rstw_r2_lost", o_RB_Data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
